// File: rtl/data_wbuf_if.sv
// data_wbuf_if: SRAM-like request/response port (req/addr_ok/data_ok handshake)
interface data_wbuf_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_wbuf.sv
// data_wbuf: posted-store write buffer; stores acked next cycle and drained in order, loads wait for hazards (WBUF_LD_BYPASS_EN lets non-matching loads pass buffered stores)
module data_wbuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic      clk,
    input  logic      aresetn,
    data_wbuf_if.slave  cpu,
    data_wbuf_if.master br,
    output logic      wbuf_empty_o
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t           state_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    logic             st_ack_q;
    logic [31:0]      addr_q  [DEPTH];
    logic [1:0]       size_q  [DEPTH];
    logic [3:0]       wstrb_q [DEPTH];
    logic [31:0]      wdata_q [DEPTH];

    logic full, empty, idle, push, pop, hazard, ld_issue, drain, ld_resp;

    assign full     = count_q == (PTR_W+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign idle     = state_q == IDLE;
    assign push     = cpu.req & cpu.wr & ~full;
    assign ld_issue = cpu.req & ~cpu.wr & idle & ~st_ack_q & ~hazard;
    assign drain    = idle & ~empty & ~ld_issue;
    assign pop      = drain & br.addr_ok;
    assign ld_resp  = (state_q == RD_WAIT) & br.data_ok;

`ifdef WBUF_LD_BYPASS_EN
    // Load hazard: only a buffered store to the same word blocks the load
    always_comb begin
        logic [PTR_W-1:0] off;
        hazard = state_q == WR_WAIT;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - head_q;
            if (({1'b0, off} < count_q) && (addr_q[i][31:2] == cpu.addr[31:2]))
                hazard = 1'b1;
        end
    end
`else
    // Load hazard: any buffered or in-flight store blocks the load
    assign hazard = ~empty | (state_q == WR_WAIT);
`endif

    // Bridge request mux: load straight from the CPU wins over draining the head entry
    always_comb begin
        br.req   = ld_issue | drain;
        br.wr    = drain;
        br.size  = drain ? size_q[head_q]  : ld_issue ? cpu.size : 2'd0;
        br.wstrb = drain ? wstrb_q[head_q] : 4'd0;
        br.addr  = drain ? addr_q[head_q]  : ld_issue ? cpu.addr : 32'd0;
        br.wdata = drain ? wdata_q[head_q] : 32'd0;
    end

    // CPU response: store acks come from st_ack_q, load data only from RD_WAIT
    always_comb begin
        cpu.addr_ok  = push | (ld_issue & br.addr_ok);
        cpu.data_ok  = st_ack_q | ld_resp;
        cpu.rdata    = ld_resp ? br.rdata : 32'd0;
        wbuf_empty_o = empty & (state_q != WR_WAIT);
    end

    // Store entry storage, written at the tail on accept
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q]  <= cpu.addr;
            size_q[tail_q]  <= cpu.size;
            wstrb_q[tail_q] <= cpu.wstrb;
            wdata_q[tail_q] <= cpu.wdata;
        end
    end

    // FIFO pointers, store ack and single-outstanding bridge FSM
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            st_ack_q <= 1'b0;
            state_q  <= IDLE;
        end else begin
            st_ack_q <= push;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            case (state_q)
                IDLE:    if (br.req && br.addr_ok) state_q <= drain ? WR_WAIT : RD_WAIT;
                RD_WAIT: if (br.data_ok) state_q <= IDLE;
                WR_WAIT: if (br.data_ok) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_wbuf.sv
// tb_data_wbuf: directed vector table plus hand sequences for data_wbuf (bypass checks under WBUF_LD_BYPASS_EN)
module tb_data_wbuf;
    logic clk, aresetn, wbuf_empty;
    int   tests = 0, fails = 0;

    data_wbuf_if cpu_if ();
    data_wbuf_if br_if ();

    data_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .aresetn(aresetn), .cpu(cpu_if), .br(br_if), .wbuf_empty_o(wbuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] req, wr, addr, wdata, baok, bdok, brdata;
        logic [31:0] aok, dok, breq, bwr, baddr, bwdata, rdata, empty;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic baok, input logic bdok,
                         input logic [31:0] brdata);
        cpu_if.req    = req;
        cpu_if.wr     = wr;
        cpu_if.size   = 2'd2;
        cpu_if.wstrb  = 4'hF;
        cpu_if.addr   = addr;
        cpu_if.wdata  = wdata;
        br_if.addr_ok = baok;
        br_if.data_ok = bdok;
        br_if.rdata   = brdata;
    endtask

    task automatic drain_one(input logic [31:0] exp_addr);
        int n = 0;
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        while (!br_if.req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_req", {31'd0, br_if.req}, 1);
        chk("drain_wr", {31'd0, br_if.wr}, 1);
        chk("drain_addr", br_if.addr, exp_addr);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          req wr addr      wdata          baok bdok brdata          aok dok breq bwr baddr     bwdata         rdata          empty
        vec[0]  = '{0, 0, 0,        0,             0, 0, 0,                0, 0, 0, 0, 0,        0,             0,             1};
        vec[1]  = '{1, 1, 'h1000,   'hDEADBEEF,    0, 0, 0,                1, 0, 0, 0, 0,        0,             0,             1};
        vec[2]  = '{0, 0, 0,        0,             0, 0, 0,                0, 1, 1, 1, 'h1000,   'hDEADBEEF,    0,             0};
        vec[3]  = '{0, 0, 0,        0,             1, 0, 0,                0, 0, 1, 1, 'h1000,   'hDEADBEEF,    0,             0};
        vec[4]  = '{0, 0, 0,        0,             0, 0, 0,                0, 0, 0, 0, 0,        0,             0,             0};
        vec[5]  = '{0, 0, 0,        0,             0, 1, 0,                0, 0, 0, 0, 0,        0,             0,             0};
        vec[6]  = '{0, 0, 0,        0,             0, 0, 0,                0, 0, 0, 0, 0,        0,             0,             1};
        vec[7]  = '{1, 1, 'h2000,   'hAAAA5555,    0, 0, 0,                1, 0, 0, 0, 0,        0,             0,             1};
        vec[8]  = '{1, 0, 'h2000,   0,             1, 0, 0,                0, 1, 1, 1, 'h2000,   'hAAAA5555,    0,             0};
        vec[9]  = '{1, 0, 'h2000,   0,             1, 0, 0,                0, 0, 0, 0, 0,        0,             0,             0};
        vec[10] = '{1, 0, 'h2000,   0,             0, 1, 'hFFFFFFFF,       0, 0, 0, 0, 0,        0,             0,             0};
        vec[11] = '{1, 0, 'h2000,   0,             1, 0, 0,                1, 0, 1, 0, 'h2000,   0,             0,             1};
        vec[12] = '{0, 0, 0,        0,             0, 1, 'h12345678,       0, 1, 0, 0, 0,        0,             'h12345678,    1};
        vec[13] = '{1, 1, 'h2004,   'h00000001,    0, 0, 0,                1, 0, 0, 0, 0,        0,             0,             1};
        vec[14] = '{1, 0, 'h2004,   0,             0, 0, 0,                0, 1, 1, 1, 'h2004,   'h00000001,    0,             0};
        vec[15] = '{1, 0, 'h2004,   0,             1, 0, 0,                0, 0, 1, 1, 'h2004,   'h00000001,    0,             0};
        vec[16] = '{0, 0, 0,        0,             0, 1, 0,                0, 0, 0, 0, 0,        0,             0,             0};
        vec[17] = '{0, 0, 0,        0,             0, 0, 0,                0, 0, 0, 0, 0,        0,             0,             1};

        aresetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vec[i].req[0], vec[i].wr[0], vec[i].addr, vec[i].wdata,
                  vec[i].baok[0], vec[i].bdok[0], vec[i].brdata);
            #1;
            chk($sformatf("v%0d_addr_ok", i), {31'd0, cpu_if.addr_ok}, vec[i].aok);
            chk($sformatf("v%0d_data_ok", i), {31'd0, cpu_if.data_ok}, vec[i].dok);
            chk($sformatf("v%0d_br_req", i),  {31'd0, br_if.req},      vec[i].breq);
            chk($sformatf("v%0d_br_wr", i),   {31'd0, br_if.wr},       vec[i].bwr);
            chk($sformatf("v%0d_br_addr", i), br_if.addr,              vec[i].baddr);
            chk($sformatf("v%0d_br_wdata", i), br_if.wdata,            vec[i].bwdata);
            chk($sformatf("v%0d_rdata", i),   cpu_if.rdata,            vec[i].rdata);
            chk($sformatf("v%0d_empty", i),   {31'd0, wbuf_empty},     vec[i].empty);
        end

        // five back-to-back stores against a stalled bridge
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 1, 32'h100 + 32'(4 * k), 32'(k + 1), 0, 0, 0);
            #1;
            chk($sformatf("full_st%0d_addr_ok", k), {31'd0, cpu_if.addr_ok}, (k < 4) ? 1 : 0);
        end
        @(negedge clk);
        #1;
        chk("full_hold_addr_ok", {31'd0, cpu_if.addr_ok}, 0);
        chk("full_head_addr", br_if.addr, 32'h100);
        chk("full_head_wdata", br_if.wdata, 32'h1);
        @(negedge clk);
        br_if.addr_ok = 1'b1;
        #1;
        chk("full_pop_blocks_push", {31'd0, cpu_if.addr_ok}, 0);
        chk("full_pop_br_req", {31'd0, br_if.req}, 1);
        @(negedge clk);
        br_if.addr_ok = 1'b0;
        #1;
        chk("full_after_pop_addr_ok", {31'd0, cpu_if.addr_ok}, 1);
        chk("full_wr_wait_br_req", {31'd0, br_if.req}, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("full_fifth_ack", {31'd0, cpu_if.data_ok}, 1);
        for (int j = 1; j < 5; j++) drain_one(32'h100 + 32'(4 * j));
        #1;
        chk("full_drained_empty", {31'd0, wbuf_empty}, 1);

        // reset while a store is in flight with three entries buffered
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 1, 32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("rst_pre_br_addr", br_if.addr, 32'h500);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pre_empty", {31'd0, wbuf_empty}, 0);
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        chk("rst_br_req", {31'd0, br_if.req}, 0);
        chk("rst_empty", {31'd0, wbuf_empty}, 1);
        chk("rst_data_ok", {31'd0, cpu_if.data_ok}, 0);
        @(negedge clk);
        #1;
        chk("rst_no_drain", {31'd0, br_if.req}, 0);
        drive(1, 1, 32'h600, 32'h66, 0, 0, 0);
        #1;
        chk("rst_store_addr_ok", {31'd0, cpu_if.addr_ok}, 1);
        drain_one(32'h600);
        #1;
        chk("rst_final_empty", {31'd0, wbuf_empty}, 1);

`ifdef WBUF_LD_BYPASS_EN
        // non-matching load passes buffered stores, matching load waits
        @(negedge clk);
        drive(1, 1, 32'h3000, 32'h30, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 32'h3010, 32'h31, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 32'h4000, 0, 1, 0, 0);
        #1;
        chk("byp_ld_addr_ok", {31'd0, cpu_if.addr_ok}, 1);
        chk("byp_ld_br_wr", {31'd0, br_if.wr}, 0);
        chk("byp_ld_br_addr", br_if.addr, 32'h4000);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        #1;
        chk("byp_ld_data_ok", {31'd0, cpu_if.data_ok}, 1);
        chk("byp_ld_rdata", cpu_if.rdata, 32'hCAFEF00D);
        @(negedge clk);
        drive(1, 0, 32'h3002, 0, 0, 0, 0);
        #1;
        chk("byp_hazard_addr_ok", {31'd0, cpu_if.addr_ok}, 0);
        chk("byp_hazard_br_wr", {31'd0, br_if.wr}, 1);
        chk("byp_hazard_br_addr", br_if.addr, 32'h3000);
        drain_one(32'h3000);
        drain_one(32'h3010);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
